// File: rtl/psum_accum_quant.sv
// Partial-sum accumulator: one bank per PE column with saturating accumulation,
// then a row-major drain that requantizes each entry to a signed OUT_BW result.
//
// state | meaning
// IDLE  | waiting for start
// ACCUM | folding valid lane psums into their banks
// DRAIN | streaming quantized entries out over the valid/ready port
// DONE  | one-cycle completion pulse, then back to IDLE
module psum_accum_quant #(
   parameter int NUM_COLS  = 32,
   parameter int PSUM_BW   = 32,
   parameter int ADDR_PSUM = 11,
   parameter int OUT_BW    = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [5:0]                    IMG_H,
   input  logic [5:0]                    IMG_W,
   input  logic [4:0]                    QSHIFT,
   input  logic                          RELU_EN,
   input  logic [PSUM_BW*NUM_COLS-1:0]   psum_rows,
   input  logic [ADDR_PSUM*NUM_COLS-1:0] psum_addrs,
   input  logic [NUM_COLS-1:0]           psum_valid,
   input  logic                          accum_last,
   output logic [OUT_BW-1:0]             out_data,
   output logic [ADDR_PSUM-1:0]          out_addr,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          busy,
   output logic                          done,
   output logic                          addr_err
);
   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
   state_t state, state_nxt;

   localparam logic signed [PSUM_BW:0] Q_MAX = {{(PSUM_BW+2-OUT_BW){1'b0}}, {(OUT_BW-1){1'b1}}};
   localparam logic signed [PSUM_BW:0] Q_MIN = {{(PSUM_BW+2-OUT_BW){1'b1}}, {(OUT_BW-1){1'b0}}};

   logic [5:0]                  cfg_h, cfg_w;
   logic [4:0]                  cfg_qshift;
   logic                        cfg_relu;
   logic [4:0]                  drn_row, drn_col;
   logic                        drn_more;
   logic                        start_acc, accum_en, drn_adv, drn_last, col_last;
   logic [NUM_COLS-1:0]         lane_err;
   logic [PSUM_BW*NUM_COLS-1:0] rd_flat;
   logic [PSUM_BW-1:0]          rd_val;
   logic signed [PSUM_BW:0]     q_ext, q_sh;
   logic [OUT_BW-1:0]           q_data;

   assign start_acc = (state == IDLE) && start;
   assign accum_en  = (state == ACCUM);
   assign drn_adv   = (state == DRAIN) && (!out_valid || out_ready);
   assign col_last  = ({1'b0, drn_col} == cfg_w - 6'd1);
   assign drn_last  = ({1'b0, drn_row} == cfg_h - 6'd1) && col_last;
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ACCUM;
         ACCUM:   if (accum_last) state_nxt = DRAIN;
         DRAIN:   if (drn_adv && !drn_more) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cfg_h      <= '0;
         cfg_w      <= '0;
         cfg_qshift <= '0;
         cfg_relu   <= 1'b0;
         addr_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (start_acc) begin
            cfg_h      <= (IMG_H > 6'd32) ? 6'd32 : IMG_H;
            cfg_w      <= (IMG_W > 6'd32) ? 6'd32 : IMG_W;
            cfg_qshift <= QSHIFT;
            cfg_relu   <= RELU_EN;
            addr_err   <= 1'b0;
         end else if (accum_en && |lane_err) begin
            addr_err <= 1'b1;
         end
      end
   end

   // Lane i owns bank i; entry index is the row field of the address.
   for (genvar i = 0; i < NUM_COLS; i++) begin : g_bank
      logic [PSUM_BW-1:0]   mem [32];
      logic [31:0]          written;
      logic [ADDR_PSUM-1:0] addr;
      logic [PSUM_BW-1:0]   psum, sat;
      logic [4:0]           ent;
      logic                 in_range, wr_en;
      logic [PSUM_BW:0]     sum;

      assign addr     = psum_addrs[ADDR_PSUM*i +: ADDR_PSUM];
      assign psum     = psum_rows[PSUM_BW*i +: PSUM_BW];
      assign ent      = addr[9:5];
      assign in_range = (addr[4:0] == 5'(i)) && (addr[ADDR_PSUM-1:5] < cfg_h)
                        && ({1'b0, addr[4:0]} < cfg_w);
      assign wr_en       = accum_en && psum_valid[i] && in_range;
      assign lane_err[i] = accum_en && psum_valid[i] && !in_range;
      assign sum = {mem[ent][PSUM_BW-1], mem[ent]} + {psum[PSUM_BW-1], psum};

      always_comb begin
         sat = sum[PSUM_BW-1:0];
         if (sum[PSUM_BW] != sum[PSUM_BW-1])
            sat = sum[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}} : {1'b0, {(PSUM_BW-1){1'b1}}};
      end

      always_ff @(posedge clk) begin
         if (wr_en) mem[ent] <= written[ent] ? sat : psum;
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset)          written <= '0;
         else if (start_acc) written <= '0;
         else if (wr_en)     written[ent] <= 1'b1;
      end

      assign rd_flat[PSUM_BW*i +: PSUM_BW] = written[drn_row] ? mem[drn_row] : '0;
   end

   assign rd_val = rd_flat[PSUM_BW*drn_col +: PSUM_BW];

   // Round-half-up is added at PSUM_BW+1 bits so the largest positive entry cannot wrap.
   always_comb begin
      q_ext = $signed({rd_val[PSUM_BW-1], rd_val});
      if (cfg_qshift != 5'd0)
         q_ext = q_ext + ((PSUM_BW+1)'(1) << (cfg_qshift - 5'd1));
      q_sh = q_ext >>> cfg_qshift;
      if (cfg_relu && (q_sh < 0)) q_sh = '0;
      if (q_sh > Q_MAX)      q_sh = Q_MAX;
      else if (q_sh < Q_MIN) q_sh = Q_MIN;
      q_data = q_sh[OUT_BW-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drn_row   <= '0;
         drn_col   <= '0;
         drn_more  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_addr  <= '0;
      end else if (accum_en && accum_last) begin
         drn_row  <= '0;
         drn_col  <= '0;
         drn_more <= (cfg_h != 6'd0) && (cfg_w != 6'd0);
      end else if (drn_adv) begin
         out_valid <= drn_more;
         if (drn_more) begin
            out_data <= q_data;
            out_addr <= ADDR_PSUM'({drn_row, drn_col});
            drn_more <= !drn_last;
            if (col_last) begin
               drn_col <= '0;
               drn_row <= drn_row + 5'd1;
            end else begin
               drn_col <= drn_col + 5'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_psum_accum_quant.sv
// Bench for psum_accum_quant: quantizer vector table plus hand-built multi-cycle tiles,
// with drained elements checked against a queue of expected (addr, data) pairs.
module tb_psum_accum_quant;
   localparam int NC = 32, PB = 32, AB = 11, OB = 8;

   logic              clk = 1'b0;
   logic              reset, start, RELU_EN, accum_last, out_ready;
   logic [5:0]        IMG_H, IMG_W;
   logic [4:0]        QSHIFT;
   logic [PB*NC-1:0]  psum_rows;
   logic [AB*NC-1:0]  psum_addrs;
   logic [NC-1:0]     psum_valid;
   logic [OB-1:0]     out_data;
   logic [AB-1:0]     out_addr;
   logic              out_valid, busy, done, addr_err;

   psum_accum_quant #(.NUM_COLS(NC), .PSUM_BW(PB), .ADDR_PSUM(AB), .OUT_BW(OB)) dut (
      .clk(clk), .reset(reset), .start(start), .IMG_H(IMG_H), .IMG_W(IMG_W),
      .QSHIFT(QSHIFT), .RELU_EN(RELU_EN), .psum_rows(psum_rows), .psum_addrs(psum_addrs),
      .psum_valid(psum_valid), .accum_last(accum_last), .out_data(out_data),
      .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
      .done(done), .addr_err(addr_err)
   );

   typedef struct {
      logic [AB-1:0] addr;
      logic [OB-1:0] data;
   } exp_t;

   typedef struct {
      logic [4:0]  q;
      logic        r;
      int          n;
      logic [31:0] a, b, c;
      int          exp;
   } qv_t;

   exp_t sb[$];
   exp_t e;
   int   n_vec = 0, n_err = 0;
   int   cyc = 0, xfer_cnt = 0, first_xfer = -1, last_xfer = -1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         if (first_xfer < 0) first_xfer = cyc;
         last_xfer = cyc;
         xfer_cnt++;
         n_vec++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_out got addr=%0d data=%0d, required no output", out_addr, $signed(out_data));
         end else begin
            e = sb.pop_front();
            if (out_addr !== e.addr || out_data !== e.data) begin
               n_err++;
               $display("FAIL drain_elem got addr=%0d data=%0d required addr=%0d data=%0d",
                        out_addr, $signed(out_data), e.addr, $signed(e.data));
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s got %0d required %0d", name, act, req);
      end
   endtask

   task automatic do_start(input logic [5:0] h, input logic [5:0] w, input logic [4:0] q, input logic r);
      IMG_H = h; IMG_W = w; QSHIFT = q; RELU_EN = r;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic put(input int lane, input int addr, input logic [31:0] v);
      psum_rows[PB*lane +: PB]  = v;
      psum_addrs[AB*lane +: AB] = AB'(addr);
      psum_valid[lane]          = 1'b1;
   endtask

   task automatic fire();
      step();
      psum_valid = '0;
   endtask

   task automatic push(input int addr, input int data);
      exp_t x;
      x.addr = AB'(addr);
      x.data = OB'(data);
      sb.push_back(x);
   endtask

   task automatic pulse_last();
      accum_last = 1'b1;
      step();
      accum_last = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      bit seen = 1'b0;
      for (int n = 0; n < budget && !seen; n++) begin
         @(negedge clk);
         seen = done;
      end
      n_vec++;
      if (!seen) begin
         n_err++;
         $display("FAIL done_timeout got no done pulse required one within %0d cycles", budget);
      end else begin
         chk("valid_low_at_done", out_valid, 0);
         @(negedge clk);
         chk("done_one_cycle", done, 0);
         chk("idle_after_done", busy, 0);
      end
      chk("sb_drained", sb.size(), 0);
      sb.delete();
   endtask

   task automatic tile_basic();
      do_start(2, 2, 0, 0);
      chk("busy_in_accum", busy, 1);
      put(0, 0, 5);
      fire();
      IMG_H = 6'd1;
      start = 1'b1;
      step();
      start = 1'b0;
      put(0, 0, 5);
      fire();
      chk("no_err_clean", addr_err, 0);
      push(0, 10); push(1, 0); push(32, 0); push(33, 0);
      pulse_last();
      chk("valid_low_on_drain_entry", out_valid, 0);
      step();
      chk("valid_one_cycle_later", out_valid, 1);
      wait_done(50);
   endtask

   task automatic load_4x4();
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            put(c, r*32 + c, r*4 + c + 1);
            push(r*32 + c, r*4 + c + 1);
         end
         fire();
      end
   endtask

   qv_t qv[14];

   initial begin
      qv[0]  = '{q: 4,  r: 0, n: 1, a: 24,           b: 0,            c: 0,            exp: 2};
      qv[1]  = '{q: 4,  r: 0, n: 1, a: -24,          b: 0,            c: 0,            exp: -1};
      qv[2]  = '{q: 4,  r: 0, n: 1, a: 4000,         b: 0,            c: 0,            exp: 127};
      qv[3]  = '{q: 4,  r: 0, n: 1, a: -4000,        b: 0,            c: 0,            exp: -128};
      qv[4]  = '{q: 0,  r: 1, n: 1, a: -50,          b: 0,            c: 0,            exp: 0};
      qv[5]  = '{q: 0,  r: 0, n: 1, a: -50,          b: 0,            c: 0,            exp: -50};
      qv[6]  = '{q: 1,  r: 0, n: 1, a: 3,            b: 0,            c: 0,            exp: 2};
      qv[7]  = '{q: 1,  r: 0, n: 1, a: -3,           b: 0,            c: 0,            exp: -1};
      qv[8]  = '{q: 2,  r: 0, n: 1, a: -7,           b: 0,            c: 0,            exp: -2};
      qv[9]  = '{q: 31, r: 0, n: 2, a: 32'h7FFFFFF0, b: 32'h7FFFFFF0, c: 0,            exp: 1};
      qv[10] = '{q: 31, r: 0, n: 2, a: 32'h80000010, b: 32'h80000010, c: 0,            exp: -1};
      qv[11] = '{q: 0,  r: 0, n: 3, a: 32'h7FFFFFF0, b: 32'h7FFFFFF0, c: 32'h80000001, exp: 0};
      qv[12] = '{q: 0,  r: 1, n: 2, a: 100,          b: 28,           c: 0,            exp: 127};
      qv[13] = '{q: 5,  r: 1, n: 2, a: -40,          b: 100,          c: 0,            exp: 2};

      reset = 1'b1; start = 1'b0; accum_last = 1'b0; out_ready = 1'b1;
      IMG_H = '0; IMG_W = '0; QSHIFT = '0; RELU_EN = 1'b0;
      psum_rows = '0; psum_addrs = '0; psum_valid = '0;
      step(); step();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_addr", out_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_addr_err", addr_err, 0);
      reset = 1'b0;
      step();

      tile_basic();

      for (int k = 0; k < 14; k++) begin
         do_start(1, 1, qv[k].q, qv[k].r);
         put(0, 0, qv[k].a); fire();
         if (qv[k].n > 1) begin put(0, 0, qv[k].b); fire(); end
         if (qv[k].n > 2) begin put(0, 0, qv[k].c); fire(); end
         push(0, qv[k].exp);
         pulse_last();
         wait_done(50);
      end

      // Bad lanes in the same cycle as a good one.
      do_start(1, 6, 0, 0);
      put(3, 4, 7); put(5, 5, 9); put(2, 34, 13); put(6, 6, 11);
      fire();
      chk("addr_err_set", addr_err, 1);
      for (int c = 0; c < 6; c++) push(c, (c == 5) ? 9 : 0);
      pulse_last();
      wait_done(50);
      chk("addr_err_sticky", addr_err, 1);

      // Oversized height clamps to 32 rows.
      do_start(40, 1, 0, 0);
      chk("addr_err_cleared", addr_err, 0);
      put(0, 992, 3);
      fire();
      for (int r = 0; r < 32; r++) push(r*32, (r == 31) ? 3 : 0);
      pulse_last();
      wait_done(100);

      do_start(0, 4, 0, 0);
      put(0, 0, 9);
      fire();
      chk("h0_addr_err", addr_err, 1);
      pulse_last();
      wait_done(10);

      // Backpressure on element 0; psums during DRAIN are ignored.
      do_start(1, 2, 0, 0);
      put(0, 0, 42); put(1, 1, 17);
      fire();
      push(0, 42); push(1, 17);
      out_ready = 1'b0;
      pulse_last();
      step();
      put(1, 1, 1000);
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         chk("stall_valid", out_valid, 1);
         chk("stall_data", out_data, 42);
         chk("stall_addr", out_addr, 0);
      end
      psum_valid = '0;
      out_ready = 1'b1;
      wait_done(50);

      do_start(4, 4, 0, 0);
      load_4x4();
      xfer_cnt = 0; first_xfer = -1; last_xfer = -1;
      pulse_last();
      wait_done(100);
      chk("tput_xfers", xfer_cnt, 16);
      chk("tput_span", last_xfer - first_xfer + 1, 16);

      // Reset in the middle of a drain.
      do_start(4, 4, 0, 0);
      load_4x4();
      xfer_cnt = 0;
      pulse_last();
      for (int n = 0; n < 100 && xfer_cnt < 3; n++) step();
      chk("mid_drain_xfers", xfer_cnt, 3);
      reset = 1'b1;
      #1;
      chk("abort_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_addr", out_addr, 0);
      sb.delete();
      step(); step();
      reset = 1'b0;
      begin
         int dcnt = 0;
         for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            dcnt += int'(done);
         end
         chk("abort_no_done", dcnt, 0);
      end
      step();
      tile_basic();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/psum_accum_quant.md
PSUM_ACCUM_QUANT -- requirements
Module: psum_accum_quant

Interface
REQ-001 Parameter NUM_COLS, default 32, SHALL be the number of psum lanes (one per PE column).
REQ-002 Parameter PSUM_BW, default 32, SHALL be the width of each psum lane and accumulator entry.
REQ-003 Parameter ADDR_PSUM, default 11, SHALL be the width of each psum address, encoded as row*32+col.
REQ-004 Parameter OUT_BW, default 8, SHALL be the width of the quantized output.
REQ-005 The block SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-006 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  single-cycle pulse that begins a tile.
REQ-009 IMG_H, IMG_W  in  6 each  tile height and width in outputs, sampled on an accepted start.
REQ-010 QSHIFT  in  5  requantization right-shift, sampled on an accepted start.
REQ-011 RELU_EN  in  1  clamps negative results to 0, sampled on an accepted start.
REQ-012 psum_rows  in  PSUM_BW*NUM_COLS  lane i occupies bits [PSUM_BW*(i+1)-1 : PSUM_BW*i], signed.
REQ-013 psum_addrs  in  ADDR_PSUM*NUM_COLS  lane i address, using the same slicing as psum_rows.
REQ-014 psum_valid  in  NUM_COLS  per-lane qualifier for psum_rows and psum_addrs.
REQ-015 accum_last  in  1  pulse meaning the PE array has finished the tile.
REQ-016 out_data  out  OUT_BW  quantized signed result.
REQ-017 out_addr  out  ADDR_PSUM  row*32+col of out_data.
REQ-018 out_valid / out_ready  out / in  1 each  output handshake.
REQ-019 busy  out  1  high whenever the state is not IDLE.
REQ-020 done  out  1  one-cycle pulse when a tile completes.
REQ-021 addr_err  out  1  sticky flag, cleared on an accepted start.

Function
REQ-022 The state machine SHALL have the states IDLE, ACCUM, DRAIN and DONE.
REQ-023 IDLE -> ACCUM SHALL occur on start; on that edge the block latches its configuration, clears all 1024 entry-written bits and clears addr_err.
REQ-024 start SHALL be ignored outside IDLE.
REQ-025 An IMG_H or IMG_W value above 32 SHALL be treated as 32.
REQ-026 Storage SHALL be 32 banks x 32 entries x PSUM_BW; lane i SHALL own bank i, and the entry index SHALL be addr[9:5].
REQ-027 In ACCUM, each lane with psum_valid=1 SHALL update its entry at that edge. If the written bit is 0, the entry SHALL be stored and the bit set; otherwise the entry SHALL become the signed saturating sum, clamped to [-2^31, 2^31-1].
REQ-028 A valid lane SHALL be dropped, and addr_err set, when any of these holds: addr[4:0] != i, addr[10:5] >= IMG_H, addr[4:0] >= IMG_W.
REQ-029 All 32 lanes SHALL be able to update in the same cycle without stall.
REQ-030 psum_valid SHALL be ignored outside ACCUM.
REQ-031 On accum_last in ACCUM, lanes valid in that same cycle SHALL still be accumulated, then the state SHALL move to DRAIN.
REQ-032 DRAIN SHALL emit entries in row-major order: row 0..IMG_H-1, col 0..IMG_W-1, with out_addr = row*32+col. Entries whose written bit is 0 SHALL read as 0.
REQ-033 Quantization SHALL proceed in this order:
- q = acc >>> QSHIFT, arithmetic shift;
- if QSHIFT > 0, add 2^(QSHIFT-1) before the shift, computed at 33 bits (round-half-up);
- if RELU_EN, replace q < 0 with 0;
- clamp q to [-128, 127].
REQ-034 out_valid SHALL first assert one cycle after entering DRAIN.
REQ-035 out_data and out_addr SHALL be registered and held stable while out_valid=1 and out_ready=0.
REQ-036 A transfer SHALL occur when out_valid and out_ready are both high; after a transfer, the next element SHALL be presented in the following cycle (one element per cycle at full throughput).
REQ-037 After the last transfer, out_valid SHALL drop; the state SHALL move to DONE, pulse done for one cycle, then return to IDLE.
REQ-038 If IMG_H=0 or IMG_W=0, DRAIN SHALL go directly to DONE with no output.
REQ-039 out_ready SHALL have no effect while out_valid=0.

Reset
REQ-040 While reset=1, the block SHALL be in IDLE with out_valid=0, out_data=0, out_addr=0, busy=0, done=0, addr_err=0, and all written bits cleared.
REQ-041 Reset asserted mid-ACCUM or mid-DRAIN SHALL abort the tile immediately with no done pulse.
REQ-042 Accumulator contents SHALL NOT require reset.

Verification
REQ-043 start with IMG_H=2, IMG_W=2, QSHIFT=0; lane0 addr 0 psum 5 on two cycles; accum_last -> outputs (addr, data) = (0,10), (1,0), (32,0), (33,0), then one done pulse.
REQ-044 QSHIFT=4, RELU_EN=0; acc values 24, -24, 4000, -4000 -> out_data 2, -1, 127, -128.
REQ-045 RELU_EN=1; acc -50 -> out_data 0; two adds of 0x7FFFFFF0 -> acc saturates at 0x7FFFFFFF.
REQ-046 lane 3 valid with addr 4 -> entry not written, addr_err=1 until the next accepted start.
REQ-047 out_ready held low for 5 cycles at element 0 -> out_data and out_addr stable, no element lost; a 4x4 tile with out_ready always high completes in 16 consecutive transfer cycles.
REQ-048 reset pulsed during DRAIN after 3 transfers -> out_valid=0 and busy=0 immediately, no done; a new start then runs a clean tile.
